// File: rtl/full_adder_if.sv
// ----------------------------------------------------------------------------
// full_adder_if : operand/result bundle for one full-adder cell.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface full_adder_if;
  logic in_valid;
  logic a;
  logic b;
  logic cin;
  logic sum;
  logic cout;
  logic out_valid;

  modport master (
    output in_valid, a, b, cin,
    input  sum, cout, out_valid
  );

  modport slave (
    input  in_valid, a, b, cin,
    output sum, cout, out_valid
  );
endinterface

`default_nettype wire

// File: rtl/full_adder.sv
// ----------------------------------------------------------------------------
// full_adder : one-bit full adder cell with optional output register.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module full_adder #(
  parameter bit REGISTERED = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  full_adder_if.slave  fa
);

  logic sum_d;
  logic cout_d;

  always_comb begin
    sum_d  = fa.a ^ fa.b ^ fa.cin;
    cout_d = (fa.a & fa.b) | (fa.a & fa.cin) | (fa.b & fa.cin);
  end

  if (REGISTERED) begin : g_reg
    // Data is loaded every cycle; out_valid alone marks it as meaningful.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        fa.sum       <= 1'b0;
        fa.cout      <= 1'b0;
        fa.out_valid <= 1'b0;
      end else begin
        fa.sum       <= sum_d;
        fa.cout      <= cout_d;
        fa.out_valid <= fa.in_valid;
      end
    end
  end else begin : g_comb
    logic unused_clk_rst;
    assign unused_clk_rst = clk & rst_n;

    always_comb begin
      fa.sum       = sum_d;
      fa.cout      = cout_d;
      fa.out_valid = fa.in_valid;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_full_adder.sv
// ----------------------------------------------------------------------------
// tb_full_adder : scoreboard bench for registered, combinational and ripple use.
// ----------------------------------------------------------------------------
`default_nettype none

module tb_full_adder;

  logic clk;
  logic rst_n;

  int checks;
  int errors;

  full_adder_if if_reg ();
  full_adder_if if_comb ();
  full_adder_if rc0 ();
  full_adder_if rc1 ();
  full_adder_if rc2 ();
  full_adder_if rc3 ();

  full_adder #(.REGISTERED(1'b1)) u_reg  (.clk(clk), .rst_n(rst_n), .fa(if_reg));
  full_adder #(.REGISTERED(1'b0)) u_comb (.clk(clk), .rst_n(rst_n), .fa(if_comb));
  full_adder #(.REGISTERED(1'b0)) u_rc0  (.clk(clk), .rst_n(rst_n), .fa(rc0));
  full_adder #(.REGISTERED(1'b0)) u_rc1  (.clk(clk), .rst_n(rst_n), .fa(rc1));
  full_adder #(.REGISTERED(1'b0)) u_rc2  (.clk(clk), .rst_n(rst_n), .fa(rc2));
  full_adder #(.REGISTERED(1'b0)) u_rc3  (.clk(clk), .rst_n(rst_n), .fa(rc3));

  // Ripple chain: each stage's carry-out feeds the next stage's carry-in.
  assign rc1.cin = rc0.cout;
  assign rc2.cin = rc1.cout;
  assign rc3.cin = rc2.cout;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] sb_reg[$];
  logic [2:0] sb_comb[$];

  task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // One clock of stimulus: compare the registered result of the previous
  // stimulus, then drive new inputs and check the combinational cell.
  task automatic step(input logic v, input logic a, input logic b, input logic c);
    logic [1:0] s2;
    logic [2:0] exp;
    @(negedge clk);
    if (sb_reg.size() > 0) begin
      exp = sb_reg.pop_front();
      check("reg", {2'b00, if_reg.out_valid, if_reg.cout, if_reg.sum}, {2'b00, exp});
    end
    s2 = {1'b0, a} + {1'b0, b} + {1'b0, c};
    if_reg.in_valid  = v;
    if_reg.a         = a;
    if_reg.b         = b;
    if_reg.cin       = c;
    if_comb.in_valid = v;
    if_comb.a        = a;
    if_comb.b        = b;
    if_comb.cin      = c;
    sb_reg.push_back({v, s2});
    sb_comb.push_back({v, s2});
    #1;
    exp = sb_comb.pop_front();
    check("comb", {2'b00, if_comb.out_valid, if_comb.cout, if_comb.sum}, {2'b00, exp});
  endtask

  task automatic ripple(input logic [3:0] x, input logic [3:0] y);
    logic [4:0] exp;
    rc0.a = x[0]; rc0.b = y[0];
    rc1.a = x[1]; rc1.b = y[1];
    rc2.a = x[2]; rc2.b = y[2];
    rc3.a = x[3]; rc3.b = y[3];
    exp = {1'b0, x} + {1'b0, y};
    #1;
    check("ripple", {rc3.cout, rc3.sum, rc2.sum, rc1.sum, rc0.sum}, exp);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    {if_reg.in_valid, if_reg.a, if_reg.b, if_reg.cin}     = 4'b1111;
    {if_comb.in_valid, if_comb.a, if_comb.b, if_comb.cin} = 4'b0000;
    rc0.in_valid = 1'b1; rc1.in_valid = 1'b1;
    rc2.in_valid = 1'b1; rc3.in_valid = 1'b1;
    rc0.cin = 1'b0;
    rc0.a = 1'b0; rc0.b = 1'b0; rc1.a = 1'b0; rc1.b = 1'b0;
    rc2.a = 1'b0; rc2.b = 1'b0; rc3.a = 1'b0; rc3.b = 1'b0;

    // Reset state held across edges even with live inputs.
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {2'b00, if_reg.out_valid, if_reg.cout, if_reg.sum}, 5'b00000);
    @(negedge clk);
    rst_n = 1'b1;

    // Exhaustive sweep, both flavours; 111 covers the all-ones case.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, i[2], i[1], i[0]);
    end
    for (int i = 7; i >= 0; i--) begin
      step(1'b0, i[2], i[1], i[0]);
    end

    // in_valid toggling 1,0,1 with a=1.
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);

    // Mid-cycle asynchronous reset while outputs are all ones.
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    check("pre_reset", {2'b00, if_reg.out_valid, if_reg.cout, if_reg.sum}, 5'b00111);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset", {2'b00, if_reg.out_valid, if_reg.cout, if_reg.sum}, 5'b00000);
    sb_reg.delete();
    @(posedge clk);
    #1;
    check("reset_hold", {2'b00, if_reg.out_valid, if_reg.cout, if_reg.sum}, 5'b00000);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("release_no_edge", {2'b00, if_reg.out_valid, if_reg.cout, if_reg.sum}, 5'b00000);
    @(posedge clk);
    #1;
    check("first_edge_load", {2'b00, if_reg.out_valid, if_reg.cout, if_reg.sum}, 5'b00111);

    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    ripple(4'b0110, 4'b1100);
    ripple(4'b1110, 4'b1000);
    ripple(4'b0111, 4'b1110);
    ripple(4'b0010, 4'b1001);
    for (int k = 0; k < 6; k++) begin
      ripple(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
